// File: rtl/conv_lane_scheduler.sv
// conv_lane_scheduler
//  Splits a job's kernel row count into passes of at most N_LANES rows and
//  presents each pass to the convolution lane array as a thermometer enable
//  mask (bit 0 upward). Jobs with an illegal row count are rejected with a
//  one-cycle error pulse. All outputs come straight from flops.
// Ports
//  CONV_SCHED_CLOCK_50     clock, rising edge
//  CONV_SCHED_RESET_InLow  async reset, active-low
//  CONV_SCHED_CfgValid/CfgReady/Wrows   job request handshake and row count
//  CONV_SCHED_Abort        synchronous abort of the job being emitted
//  CONV_SCHED_SelValid/SelReady/Sel     lane mask handshake and mask
//  CONV_SCHED_Pass         0-based index of the presented pass
//  CONV_SCHED_Last         presented pass is the final one of the job
//  CONV_SCHED_Err          one-cycle pulse on a rejected row count
module conv_lane_scheduler #(
   parameter int unsigned N_LANES         = 13,
   parameter int unsigned BITWIDTH_W_ROWS = 6,
   parameter int unsigned MAX_ROWS        = 39,
   parameter int unsigned BITWIDTH_PASS   = 2
) (
   input  logic                       CONV_SCHED_CLOCK_50,
   input  logic                       CONV_SCHED_RESET_InLow,
   input  logic                       CONV_SCHED_CfgValid,
   output logic                       CONV_SCHED_CfgReady,
   input  logic [BITWIDTH_W_ROWS-1:0] CONV_SCHED_Wrows,
   input  logic                       CONV_SCHED_Abort,
   output logic                       CONV_SCHED_SelValid,
   input  logic                       CONV_SCHED_SelReady,
   output logic [N_LANES-1:0]         CONV_SCHED_Sel,
   output logic [BITWIDTH_PASS-1:0]   CONV_SCHED_Pass,
   output logic                       CONV_SCHED_Last,
   output logic                       CONV_SCHED_Err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [BITWIDTH_W_ROWS-1:0] rem_q, rem_d;
   logic [BITWIDTH_PASS-1:0]   pass_q, pass_d;
   logic [N_LANES-1:0]         sel_q, sel_d;
   logic                       last_q, last_d;
   logic                       err_q, err_d;
   logic                       sel_valid_q, sel_valid_d;
   logic                       cfg_ready_q, cfg_ready_d;

   logic                       accept;
   logic                       rows_bad;
   logic                       handshake;

   // Thermometer mask with min(rem, N_LANES) low bits set.
   function automatic logic [N_LANES-1:0] lane_mask(input logic [BITWIDTH_W_ROWS-1:0] rem);
      logic [N_LANES-1:0] m;
      for (int unsigned i = 0; i < N_LANES; i++) begin
         m[i] = (32'(rem) > i);
      end
      return m;
   endfunction

   assign accept    = CONV_SCHED_CfgValid & cfg_ready_q;
   assign rows_bad  = (CONV_SCHED_Wrows == '0) || (32'(CONV_SCHED_Wrows) > MAX_ROWS);
   assign handshake = sel_valid_q & CONV_SCHED_SelReady;

   // Next-state and next-output decode.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      pass_d      = pass_q;
      sel_d       = sel_q;
      last_d      = last_q;
      err_d       = 1'b0;
      sel_valid_d = sel_valid_q;
      cfg_ready_d = cfg_ready_q;

      unique case (state_q)
         ST_IDLE: begin
            // Abort is ignored here, so it cannot block a same-cycle accept.
            if (accept) begin
               if (rows_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = ST_EMIT;
                  rem_d       = CONV_SCHED_Wrows;
                  pass_d      = '0;
                  sel_d       = lane_mask(CONV_SCHED_Wrows);
                  last_d      = (32'(CONV_SCHED_Wrows) <= N_LANES);
                  sel_valid_d = 1'b1;
                  cfg_ready_d = 1'b0;
               end
            end
         end
         ST_EMIT: begin
            if (CONV_SCHED_Abort || (handshake && last_q)) begin
               // Abort takes priority over a simultaneous consume.
               state_d     = ST_IDLE;
               pass_d      = '0;
               sel_d       = '0;
               last_d      = 1'b0;
               sel_valid_d = 1'b0;
               cfg_ready_d = 1'b1;
            end else if (handshake) begin
               // Not last implies rem > N_LANES, so the subtraction cannot underflow.
               rem_d  = rem_q - BITWIDTH_W_ROWS'(N_LANES);
               pass_d = pass_q + BITWIDTH_PASS'(1);
               sel_d  = lane_mask(rem_d);
               last_d = (32'(rem_d) <= N_LANES);
            end
         end
         default: begin
            state_d     = ST_IDLE;
            sel_d       = '0;
            sel_valid_d = 1'b0;
            cfg_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CONV_SCHED_CLOCK_50 or negedge CONV_SCHED_RESET_InLow) begin
      if (!CONV_SCHED_RESET_InLow) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         pass_q      <= '0;
         sel_q       <= '0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         sel_valid_q <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         pass_q      <= pass_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         err_q       <= err_d;
         sel_valid_q <= sel_valid_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign CONV_SCHED_CfgReady = cfg_ready_q;
   assign CONV_SCHED_SelValid = sel_valid_q;
   assign CONV_SCHED_Sel      = sel_q;
   assign CONV_SCHED_Pass     = pass_q;
   assign CONV_SCHED_Last     = last_q;
   assign CONV_SCHED_Err      = err_q;

endmodule

// File: tb/tb_conv_lane_scheduler.sv
// Testbench for conv_lane_scheduler: directed scenarios plus a randomized run
// checked against a pass-list reference model.
module tb_conv_lane_scheduler;

   localparam int unsigned N    = 13;
   localparam int unsigned BW   = 6;
   localparam int unsigned MAXR = 39;
   localparam int unsigned BP   = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [BW-1:0] wrows;
   logic          abort;
   logic          sel_valid;
   logic          sel_ready;
   logic [N-1:0]  sel;
   logic [BP-1:0] pass;
   logic          last;
   logic          err;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [N-1:0]  sel;
      logic [BP-1:0] pass;
      logic          last;
   } pass_t;

   pass_t q[$];

   conv_lane_scheduler #(
      .N_LANES(N), .BITWIDTH_W_ROWS(BW), .MAX_ROWS(MAXR), .BITWIDTH_PASS(BP)
   ) dut (
      .CONV_SCHED_CLOCK_50   (clk),
      .CONV_SCHED_RESET_InLow(rst_n),
      .CONV_SCHED_CfgValid   (cfg_valid),
      .CONV_SCHED_CfgReady   (cfg_ready),
      .CONV_SCHED_Wrows      (wrows),
      .CONV_SCHED_Abort      (abort),
      .CONV_SCHED_SelValid   (sel_valid),
      .CONV_SCHED_SelReady   (sel_ready),
      .CONV_SCHED_Sel        (sel),
      .CONV_SCHED_Pass       (pass),
      .CONV_SCHED_Last       (last),
      .CONV_SCHED_Err        (err)
   );

   always #5 clk = ~clk;

   // Observed {SelValid, Sel, Err, CfgReady} and {Pass, Last}.
   function automatic logic [15:0] ctl();
      return {sel_valid, sel, err, cfg_ready};
   endfunction

   function automatic logic [2:0] pl();
      return {pass, last};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a job of 'rows' rows becomes a list of passes of up to N rows.
   task automatic build(input int rows);
      int rem;
      int p;
      int n;
      logic [31:0] m;
      pass_t e;
      q.delete();
      rem = rows;
      p   = 0;
      while (rem > 0) begin
         n = (rem < int'(N)) ? rem : int'(N);
         m = (32'h1 << n) - 32'h1;
         e.sel  = m[N-1:0];
         e.pass = BP'(p);
         e.last = (rem <= int'(N));
         q.push_back(e);
         rem -= n;
         p++;
      end
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      rst_n = 1'b0; cfg_valid = 1'b0; wrows = '0; abort = 1'b0; sel_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp = {1'b0, 13'h0000, 1'b0, 1'b1};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL reset_ctl: got %h want %h", ctl(), exp); end
      total++; if (pl() !== 3'b000) begin bad++; $display("FAIL reset_pass_last: got %b want 000", pl()); end
      #3 rst_n = 1'b1;
      tick();
      total++; if (ctl() !== exp) begin bad++; $display("FAIL reset_release: got %h want %h", ctl(), exp); end
   endtask

   // Wrows=5: single pass.
   task automatic test_single_pass();
      logic [15:0] exp;
      cfg_valid = 1'b1; wrows = 6'd5; sel_ready = 1'b1;
      tick();
      cfg_valid = 1'b0;
      exp = {1'b1, 13'h001F, 1'b0, 1'b0};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t1_ctl: got %h want %h", ctl(), exp); end
      total++; if (pl() !== 3'b001) begin bad++; $display("FAIL t1_pass_last: got %b want 001", pl()); end
      tick();
      exp = {1'b0, 13'h0000, 1'b0, 1'b1};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t1_idle: got %h want %h", ctl(), exp); end
   endtask

   // Wrows=30: three back-to-back passes.
   task automatic test_multi_pass();
      logic [15:0] exp;
      logic [N-1:0] sels [3];
      sels[0] = 13'h1FFF; sels[1] = 13'h1FFF; sels[2] = 13'h000F;
      cfg_valid = 1'b1; wrows = 6'd30; sel_ready = 1'b1;
      tick();
      cfg_valid = 1'b0;
      for (int p = 0; p < 3; p++) begin
         exp = {1'b1, sels[p], 1'b0, 1'b0};
         total++; if (ctl() !== exp) begin bad++; $display("FAIL t2_ctl_p%0d: got %h want %h", p, ctl(), exp); end
         total++; if (pl() !== {2'(p), p == 2}) begin bad++; $display("FAIL t2_pass_last_p%0d: got %b want %b", p, pl(), {2'(p), p == 2}); end
         tick();
      end
      exp = {1'b0, 13'h0000, 1'b0, 1'b1};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t2_idle: got %h want %h", ctl(), exp); end
   endtask

   // Wrows=0 and Wrows=40 rejected.
   task automatic test_err();
      logic [15:0] exp;
      logic [BW-1:0] badv [2];
      badv[0] = 6'd0; badv[1] = 6'd40;
      for (int i = 0; i < 2; i++) begin
         cfg_valid = 1'b1; wrows = badv[i];
         tick();
         cfg_valid = 1'b0;
         exp = {1'b0, 13'h0000, 1'b1, 1'b1};
         total++; if (ctl() !== exp) begin bad++; $display("FAIL t3_err_%0d: got %h want %h", badv[i], ctl(), exp); end
         tick();
         exp = {1'b0, 13'h0000, 1'b0, 1'b1};
         total++; if (ctl() !== exp) begin bad++; $display("FAIL t3_pulse_%0d: got %h want %h", badv[i], ctl(), exp); end
      end
   endtask

   // Wrows=26 with a 4-cycle stall on pass 0; Wrows changes mid-job.
   task automatic test_stall();
      logic [15:0] exp;
      cfg_valid = 1'b1; wrows = 6'd26; sel_ready = 1'b0;
      tick();
      cfg_valid = 1'b0; wrows = 6'd3;
      for (int i = 0; i < 4; i++) begin
         exp = {1'b1, 13'h1FFF, 1'b0, 1'b0};
         total++; if (ctl() !== exp) begin bad++; $display("FAIL t4_hold_%0d: got %h want %h", i, ctl(), exp); end
         total++; if (pl() !== 3'b000) begin bad++; $display("FAIL t4_hold_pl_%0d: got %b want 000", i, pl()); end
         tick();
      end
      sel_ready = 1'b1;
      tick();
      exp = {1'b1, 13'h1FFF, 1'b0, 1'b0};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t4_p1: got %h want %h", ctl(), exp); end
      total++; if (pl() !== 3'b011) begin bad++; $display("FAIL t4_p1_pl: got %b want 011", pl()); end
      tick();
   endtask

   // Wrows=39 aborted on pass 1, then new jobs including accept during an idle abort.
   task automatic test_abort();
      logic [15:0] exp;
      cfg_valid = 1'b1; wrows = 6'd39; sel_ready = 1'b1;
      tick();
      cfg_valid = 1'b0;
      total++; if (pl() !== 3'b000) begin bad++; $display("FAIL t5_p0_pl: got %b want 000", pl()); end
      tick();
      total++; if (pl() !== 3'b010) begin bad++; $display("FAIL t5_p1_pl: got %b want 010", pl()); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp = {1'b0, 13'h0000, 1'b0, 1'b1};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t5_aborted: got %h want %h", ctl(), exp); end
      cfg_valid = 1'b1; wrows = 6'd13;
      tick();
      cfg_valid = 1'b0;
      exp = {1'b1, 13'h1FFF, 1'b0, 1'b0};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t5_new_job: got %h want %h", ctl(), exp); end
      total++; if (pl() !== 3'b001) begin bad++; $display("FAIL t5_new_pl: got %b want 001", pl()); end
      tick();
      abort = 1'b1; cfg_valid = 1'b1; wrows = 6'd1;
      tick();
      abort = 1'b0; cfg_valid = 1'b0;
      exp = {1'b1, 13'h0001, 1'b0, 1'b0};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t5_idle_abort_accept: got %h want %h", ctl(), exp); end
      tick();
   endtask

   // Async reset mid-EMIT.
   task automatic test_async_reset();
      logic [15:0] exp;
      cfg_valid = 1'b1; wrows = 6'd20; sel_ready = 1'b0;
      tick();
      cfg_valid = 1'b0;
      total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL t6_emit: got %b want 1", sel_valid); end
      #2 rst_n = 1'b0;
      #1;
      exp = {1'b0, 13'h0000, 1'b0, 1'b1};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t6_async_ctl: got %h want %h", ctl(), exp); end
      total++; if (pl() !== 3'b000) begin bad++; $display("FAIL t6_async_pl: got %b want 000", pl()); end
      #3 rst_n = 1'b1;
      tick();
      cfg_valid = 1'b1; wrows = 6'd7; sel_ready = 1'b1;
      tick();
      cfg_valid = 1'b0;
      exp = {1'b1, 13'h007F, 1'b0, 1'b0};
      total++; if (ctl() !== exp) begin bad++; $display("FAIL t6_after: got %h want %h", ctl(), exp); end
      tick();
   endtask

   // Random traffic against the pass-list model.
   task automatic test_random();
      logic [15:0] exp;
      logic exp_err;
      q.delete();
      exp_err = 1'b0;
      repeat (400) begin
         if (q.size() > 0) exp = {1'b1, q[0].sel, exp_err, 1'b0};
         else              exp = {1'b0, 13'h0000, exp_err, 1'b1};
         total++; if (ctl() !== exp) begin bad++; $display("FAIL rnd_ctl @%0t: got %h want %h", $time, ctl(), exp); end
         if (q.size() > 0) begin
            total++; if (pl() !== {q[0].pass, q[0].last}) begin bad++; $display("FAIL rnd_pl @%0t: got %b want %b", $time, pl(), {q[0].pass, q[0].last}); end
         end
         cfg_valid = 1'($urandom_range(0, 1));
         wrows     = BW'($urandom_range(0, 45));
         sel_ready = ($urandom_range(0, 9) < 7);
         abort     = ($urandom_range(0, 19) == 0);
         exp_err   = 1'b0;
         if (q.size() == 0) begin
            if (cfg_valid) begin
               if (wrows == 0 || int'(wrows) > int'(MAXR)) exp_err = 1'b1;
               else build(int'(wrows));
            end
         end else if (abort) begin
            q.delete();
         end else if (sel_ready) begin
            void'(q.pop_front());
         end
         tick();
      end
      cfg_valid = 1'b0; abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_err();
      test_stall();
      test_abort();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
